// File: rtl/multiplicador_pkg.sv
// Shared constants and types for the unsigned array multiplier.
package multiplicador_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w;
    endfunction

    // Reference product type at the default operand width.
    typedef logic [prod_width(DEFAULT_WIDTH)-1:0] prod_default_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple-carry rows of the array.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/multiplicador.sv
// Unsigned WIDTH x WIDTH array multiplier with one registered output stage and valid handshake.
module multiplicador
    import multiplicador_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic [WIDTH-1:0]                   a_i,
    input  logic [WIDTH-1:0]                   b_i,
    input  logic                               valid_i,
    output logic [prod_width(WIDTH)-1:0]       m_o,
    output logic                               valid_o
);

    localparam int unsigned PW = prod_width(WIDTH);

    logic [WIDTH-1:0] pp  [WIDTH];
    logic [WIDTH:0]   row [WIDTH];
    logic [PW-1:0]    prod;
    logic [PW-1:0]    m_q;
    logic             valid_q;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
        assign pp[gi] = a_i & {WIDTH{b_i[gi]}};
    end

    assign row[0] = {1'b0, pp[0]};

    // Each row adds its partial product to the upper bits of the previous row's sum;
    // the previous row's LSB is final and drops out as a product bit.
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_row
        logic [WIDTH:0]   c;
        logic [WIDTH-1:0] s;

        assign c[0] = 1'b0;

        for (genvar gj = 0; gj < WIDTH; gj++) begin : g_fa
            full_adder u_fa (
                .a    (row[gi-1][gj+1]),
                .b    (pp[gi][gj]),
                .cin  (c[gj]),
                .s    (s[gj]),
                .cout (c[gj+1])
            );
        end

        assign row[gi] = {c[WIDTH], s};
    end

    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_low
        assign prod[gi] = row[gi][0];
    end

    assign prod[PW-1:WIDTH-1] = row[WIDTH-1];

    // Capture only when valid so unknown idle operands never reach the output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            m_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                m_q <= prod;
            end
        end
    end

    assign m_o     = m_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_multiplicador.sv
// Self-checking bench: WIDTH=2 directed/exhaustive/hold/random, plus WIDTH=4 and WIDTH=8 sweeps.
module tb_multiplicador;
    import multiplicador_pkg::*;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] m;
    } vec2_t;

    typedef struct {
        logic [3:0]  a4;
        logic [3:0]  b4;
        logic [7:0]  m4;
        logic [7:0]  a8;
        logic [7:0]  b8;
        logic [15:0] m8;
    } vecw_t;

    logic        clk;
    logic        rst_n;

    logic [1:0]    a2, b2;
    logic          v2, vo2;
    prod_default_t m2;

    logic [3:0]  a4, b4;
    logic        v4, vo4;
    logic [7:0]  m4;

    logic [7:0]  a8, b8;
    logic        v8, vo8;
    logic [15:0] m8;

    int total;
    int bad;

    multiplicador #(.WIDTH(2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a2), .b_i(b2), .valid_i(v2), .m_o(m2), .valid_o(vo2)
    );
    multiplicador #(.WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a4), .b_i(b4), .valid_i(v4), .m_o(m4), .valid_o(vo4)
    );
    multiplicador #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .a_i(a8), .b_i(b8), .valid_i(v8), .m_o(m8), .valid_o(vo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec2_t dir [4];
        vecw_t swp [3];
        logic [3:0] exp_m;
        logic       exp_v;

        dir[0] = '{a: 2'd3, b: 2'd3, m: 4'd9};
        dir[1] = '{a: 2'd2, b: 2'd3, m: 4'd6};
        dir[2] = '{a: 2'd1, b: 2'd1, m: 4'd1};
        dir[3] = '{a: 2'd0, b: 2'd3, m: 4'd0};

        swp[0] = '{a4: 4'd15, b4: 4'd15, m4: 8'd225, a8: 8'd255, b8: 8'd255, m8: 16'd65025};
        swp[1] = '{a4: 4'd0,  b4: 4'd9,  m4: 8'd0,   a8: 8'd0,   b8: 8'd200, m8: 16'd0};
        swp[2] = '{a4: 4'd7,  b4: 4'd13, m4: 8'd91,  a8: 8'd123, b8: 8'd45,  m8: 16'd5535};

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        a2 = '0; b2 = '0; v2 = 1'b0;
        a4 = '0; b4 = '0; v4 = 1'b0;
        a8 = '0; b8 = '0; v8 = 1'b0;

        // Reset state
        step();
        check("reset_m", 32'(m2), 32'd0);
        check("reset_v", 32'(vo2), 32'd0);

        // Release, capture 2x3, then pull reset mid-cycle
        rst_n = 1'b1;
        a2 = 2'd2; b2 = 2'd3; v2 = 1'b1;
        step();
        check("pre_reset_m", 32'(m2), 32'd6);
        check("pre_reset_v", 32'(vo2), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_m", 32'(m2), 32'd0);
        check("async_reset_v", 32'(vo2), 32'd0);
        v2 = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_reset_idle_v", 32'(vo2), 32'd0);
            check("post_reset_idle_m", 32'(m2), 32'd0);
        end

        // Directed table, back-to-back
        for (int i = 0; i < 4; i++) begin
            a2 = dir[i].a; b2 = dir[i].b; v2 = 1'b1;
            step();
            check($sformatf("dir%0d_m", i), 32'(m2), 32'(dir[i].m));
            check($sformatf("dir%0d_v", i), 32'(vo2), 32'd1);
        end

        // Exhaustive WIDTH=2, valid held high throughout
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                a2 = 2'(a); b2 = 2'(b); v2 = 1'b1;
                step();
                check($sformatf("exh_%0dx%0d_m", a, b), 32'(m2), 32'(a * b));
                check($sformatf("exh_%0dx%0d_v", a, b), 32'(vo2), 32'd1);
            end
        end

        // Hold with idle operand changes, including unknowns
        a2 = 2'd2; b2 = 2'd2; v2 = 1'b1;
        step();
        check("hold_cap_m", 32'(m2), 32'd4);
        a2 = 2'd3; b2 = 2'd1; v2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold%0d_m", i), 32'(m2), 32'd4);
            check($sformatf("hold%0d_v", i), 32'(vo2), 32'd0);
        end
        a2 = 2'bxx; b2 = 2'bx1;
        step();
        check("hold_x_m", 32'(m2), 32'd4);
        check("hold_x_v", 32'(vo2), 32'd0);

        // Random operands and valid against a delayed reference
        exp_m = 4'd4;
        for (int i = 0; i < 100; i++) begin
            a2 = 2'($urandom_range(0, 3));
            b2 = 2'($urandom_range(0, 3));
            v2 = 1'($urandom_range(0, 1));
            exp_v = v2;
            if (v2) exp_m = 4'(int'(a2) * int'(b2));
            step();
            check($sformatf("rnd%0d_m", i), 32'(m2), 32'(exp_m));
            check($sformatf("rnd%0d_v", i), 32'(vo2), 32'(exp_v));
        end
        v2 = 1'b0;

        // Wider configurations
        for (int i = 0; i < 3; i++) begin
            a4 = swp[i].a4; b4 = swp[i].b4; v4 = 1'b1;
            a8 = swp[i].a8; b8 = swp[i].b8; v8 = 1'b1;
            step();
            check($sformatf("w4_%0d_m", i), 32'(m4), 32'(swp[i].m4));
            check($sformatf("w4_%0d_v", i), 32'(vo4), 32'd1);
            check($sformatf("w8_%0d_m", i), 32'(m8), 32'(swp[i].m8));
            check($sformatf("w8_%0d_v", i), 32'(vo8), 32'd1);
        end
        v4 = 1'b0; v8 = 1'b0;
        step();
        check("w8_idle_v", 32'(vo8), 32'd0);
        check("w8_idle_m", 32'(m8), 32'd5535);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
